// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter: master drives controls, slave is the counter.
// With PARAM_UPDOWN_COUNTER_CAPTURE_EN defined the bundle also carries capture/cap_val.
interface param_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             enable;
    logic             up;
    logic             sat;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_bar;
    logic             wrap;
    logic             at_limit;
`ifdef PARAM_UPDOWN_COUNTER_CAPTURE_EN
    logic             capture;
    logic [WIDTH-1:0] cap_val;

    modport master (
        output clr, load, load_val, enable, up, sat, capture,
        input  count, count_bar, wrap, at_limit, cap_val
    );
    modport slave (
        input  clr, load, load_val, enable, up, sat, capture,
        output count, count_bar, wrap, at_limit, cap_val
    );
`else
    modport master (
        output clr, load, load_val, enable, up, sat,
        input  count, count_bar, wrap, at_limit
    );
    modport slave (
        input  clr, load, load_val, enable, up, sat,
        output count, count_bar, wrap, at_limit
    );
`endif
endinterface

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with prescaler, wrap/saturate modes and registered wrap pulse.
// Optional input capture register enabled by defining PARAM_UPDOWN_COUNTER_CAPTURE_EN.
module param_updown_counter #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] MODULUS_MAX = {WIDTH{1'b1}},
    parameter int               PRESCALE    = 1,
    parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}}
) (
    input logic                    clk,
    input logic                    rst,
    param_updown_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [15:0]      PRE_LAST = 16'(PRESCALE - 1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic [WIDTH-1:0] step_count_s;
    logic             step_wrap_s;
    logic [15:0]      pre_r;
    logic [15:0]      pre_nxt_s;
    logic             wrap_r;
    logic             wrap_nxt_s;

    // Value and wrap flag the counter would take if this edge were a step
    always_comb begin
        step_count_s = count_r;
        step_wrap_s  = 1'b0;
        if (bus.up) begin
            if (count_r < MODULUS_MAX) begin
                step_count_s = count_r + ONE;
            end else begin
                // Out-of-range values also land here and recover to zero
                step_wrap_s = 1'b1;
                if (bus.sat && (count_r == MODULUS_MAX)) begin
                    step_count_s = count_r;
                end else begin
                    step_count_s = ZERO;
                end
            end
        end else begin
            if (count_r != ZERO) begin
                step_count_s = count_r - ONE;
            end else begin
                step_wrap_s = 1'b1;
                if (bus.sat) begin
                    step_count_s = count_r;
                end else begin
                    step_count_s = MODULUS_MAX;
                end
            end
        end
    end

    // Next-state selection: clr over load over prescaled step
    always_comb begin
        count_nxt_s = count_r;
        pre_nxt_s   = pre_r;
        wrap_nxt_s  = 1'b0;
        if (bus.clr) begin
            count_nxt_s = ZERO;
            pre_nxt_s   = 16'd0;
        end else if (bus.load) begin
            if (bus.load_val > MODULUS_MAX) begin
                count_nxt_s = MODULUS_MAX;
            end else begin
                count_nxt_s = bus.load_val;
            end
            pre_nxt_s = 16'd0;
        end else if (bus.enable) begin
            if (pre_r == PRE_LAST) begin
                pre_nxt_s   = 16'd0;
                count_nxt_s = step_count_s;
                wrap_nxt_s  = step_wrap_s;
            end else begin
                pre_nxt_s = pre_r + 16'd1;
            end
        end else begin
            pre_nxt_s = pre_r;
        end
    end

    // Counter, prescaler and wrap pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= RST_VAL;
            pre_r   <= 16'd0;
            wrap_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            pre_r   <= pre_nxt_s;
            wrap_r  <= wrap_nxt_s;
        end
    end

`ifdef PARAM_UPDOWN_COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] cap_r;

    // Capture samples the pre-update count, independent of clr/load/step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_r <= ZERO;
        end else if (bus.capture) begin
            cap_r <= count_r;
        end else begin
            cap_r <= cap_r;
        end
    end

    assign bus.cap_val = cap_r;
`endif

    assign bus.count     = count_r;
    assign bus.count_bar = ~count_r;
    assign bus.wrap      = wrap_r;
    assign bus.at_limit  = (bus.up && (count_r == MODULUS_MAX)) ||
                           (!bus.up && (count_r == ZERO));

endmodule
